// File: rtl/fetch_sprime_sram.sv
// Fetches one pre-IDCT coefficient block (16x16 Y or 8x8 U/V) from SRAM, column-major, into S' RAM port A as row pairs.
// Optional FETCH_SP_ZERO_DETECT_EN adds all_zero, flagging a block whose fetched samples were all zero.
module fetch_sprime_sram #(
  parameter int Y_BASE    = 76800,
  parameter int U_BASE    = 153600,
  parameter int V_BASE    = 192000,
  parameter int Y_STRIDE  = 320,
  parameter int UV_STRIDE = 160,
  parameter int SRAM_LAT  = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        start,
  input  logic        Y_finished,
  input  logic        U_finished,
  input  logic [7:0]  Rb,
  input  logic [7:0]  Cb,
  input  logic [15:0] SRAM_read_data,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  output logic [7:0]  Address_Sp_a,
  output logic [31:0] Write_data_Sp_a,
  output logic        Write_en_Sp_a,
  output logic        busy,
  output logic        done
`ifdef FETCH_SP_ZERO_DETECT_EN
  ,
  output logic        all_zero
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              state, state_nxt;
  logic                is_y;
  logic [17:0]         base;
  logic [8:0]          stride;
  logic [7:0]          rb_q, cb_q;
  logic [3:0]          ri, ci, n_last;
  logic [SRAM_LAT-1:0] vld_sr, par_sr;
  logic [15:0]         even_q;
  logic [17:0]         ra, ca;
  logic                issuing, last_issue, accept, samp_vld, samp_odd;

  assign n_last     = is_y ? 4'd15 : 4'd7;
  assign issuing    = (state == S_ISSUE);
  assign last_issue = issuing && (ri == n_last) && (ci == n_last);
  assign accept     = (state == S_IDLE) && start;
  assign samp_vld   = vld_sr[SRAM_LAT-1];
  assign samp_odd   = par_sr[SRAM_LAT-1];

  // Block origin is Rb*N / Cb*N; everything wraps at 18 bits.
  always_comb begin
    ra = '0;
    ca = '0;
    if (is_y) begin
      ra = {6'b0, rb_q, 4'b0} + {14'b0, ri};
      ca = {6'b0, cb_q, 4'b0} + {14'b0, ci};
    end else begin
      ra = {7'b0, rb_q, 3'b0} + {14'b0, ri};
      ca = {7'b0, cb_q, 3'b0} + {14'b0, ci};
    end
  end

  assign SRAM_address    = issuing ? (base + ra * {9'b0, stride} + ca) : '0;
  assign SRAM_we_n       = 1'b1;
  assign Write_en_Sp_a   = samp_vld && samp_odd;
  assign Write_data_Sp_a = Write_en_Sp_a ? {even_q, SRAM_read_data} : '0;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: begin
        busy = 1'b1;
        if (last_issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Leave once only the final (oldest) read remains; its write happens this cycle.
        if ((vld_sr << 1) == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= S_IDLE;
      is_y         <= 1'b0;
      base         <= '0;
      stride       <= '0;
      rb_q         <= '0;
      cb_q         <= '0;
      ri           <= '0;
      ci           <= '0;
      vld_sr       <= '0;
      par_sr       <= '0;
      even_q       <= '0;
      Address_Sp_a <= '0;
    end else begin
      state  <= state_nxt;
      vld_sr <= (vld_sr << 1) | SRAM_LAT'(issuing);
      par_sr <= (par_sr << 1) | SRAM_LAT'(issuing && ri[0]);
      if (accept) begin
        is_y         <= ~Y_finished;
        base         <= !Y_finished ? 18'(Y_BASE) : (U_finished ? 18'(V_BASE) : 18'(U_BASE));
        stride       <= !Y_finished ? 9'(Y_STRIDE) : 9'(UV_STRIDE);
        rb_q         <= Rb;
        cb_q         <= Cb;
        ri           <= '0;
        ci           <= '0;
        Address_Sp_a <= '0;
      end
      if (issuing) begin
        ri <= (ri == n_last) ? 4'd0 : ri + 4'd1;
        if (ri == n_last) ci <= ci + 4'd1;
      end
      if (samp_vld && !samp_odd) even_q <= SRAM_read_data;
      if (Write_en_Sp_a) Address_Sp_a <= Address_Sp_a + 8'd1;
    end
  end

`ifdef FETCH_SP_ZERO_DETECT_EN
  logic nz_q, nz_nxt;

  assign nz_nxt = nz_q || (samp_vld && (SRAM_read_data != 16'h0000));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      nz_q     <= 1'b0;
      all_zero <= 1'b0;
    end else if (accept) begin
      nz_q     <= 1'b0;
      all_zero <= 1'b0;
    end else begin
      nz_q <= nz_nxt;
      if (state == S_DRAIN && state_nxt == S_DONE) all_zero <= ~nz_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sprime_sram.sv
// Directed and randomized block fetches against a latency-2 SRAM model; expected traffic derived from block geometry.
module tb_fetch_sprime_sram;

  localparam int YB = 76800, UB = 153600, VB = 192000;
  localparam int YS = 320, UVS = 160, LAT = 2;

  logic        Clock = 1'b0;
  logic        Reset, start, Y_finished, U_finished;
  logic [7:0]  Rb, Cb;
  logic [15:0] SRAM_read_data;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [7:0]  Address_Sp_a;
  logic [31:0] Write_data_Sp_a;
  logic        Write_en_Sp_a, busy, done;
`ifdef FETCH_SP_ZERO_DETECT_EN
  logic        all_zero;
`endif

  fetch_sprime_sram dut (
    .Clock(Clock), .Reset(Reset), .start(start),
    .Y_finished(Y_finished), .U_finished(U_finished), .Rb(Rb), .Cb(Cb),
    .SRAM_read_data(SRAM_read_data), .SRAM_address(SRAM_address), .SRAM_we_n(SRAM_we_n),
    .Address_Sp_a(Address_Sp_a), .Write_data_Sp_a(Write_data_Sp_a),
    .Write_en_Sp_a(Write_en_Sp_a), .busy(busy), .done(done)
`ifdef FETCH_SP_ZERO_DETECT_EN
    , .all_zero(all_zero)
`endif
  );

  always #5 Clock = ~Clock;

  int          checks = 0;
  int          errors = 0;
  int          pat_mode = 0;
  logic [17:0] nz_addr = '0;
  logic [31:0] seed = '0;
  logic [17:0] addr_d1;

  function automatic logic [15:0] sram_val(input logic [17:0] a);
    logic [31:0] h;
    h = ({14'b0, a} * 32'h9E3779B1) ^ seed;
    case (pat_mode)
      0:       return a[15:0];
      1:       return (a == nz_addr) ? 16'h0001 : 16'h0000;
      default: return h[31:16];
    endcase
  endfunction

  // Address seen in cycle n returns data in cycle n+2.
  always @(posedge Clock) begin
    addr_d1        <= SRAM_address;
    SRAM_read_data <= sram_val(addr_d1);
  end

  function automatic int ref_addr(input int base, stride, n, rb, cb, ri, ci);
    return (base + (rb * n + ri) * stride + cb * n + ci) & 32'h3FFFF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, SRAM_address, 0);
    chk({tag, "_we_n"}, SRAM_we_n, 1);
    chk({tag, "_sp_addr"}, Address_Sp_a, 0);
    chk({tag, "_wdata"}, Write_data_Sp_a, 0);
    chk({tag, "_wen"}, Write_en_Sp_a, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
`ifdef FETCH_SP_ZERO_DETECT_EN
    chk({tag, "_all_zero"}, all_zero, 0);
`endif
  endtask

  // Called at a negedge; drives start in the current cycle (cycle 0).
  task automatic run_fetch(input logic yf, input logic uf, input logic [7:0] rb, input logic [7:0] cb,
                           input int sa1, input int sa2, input int rst_at);
    int n, base, stride, nn, dcyc, last_c, ri, ci, kk;
    bit nonzero;
    int q_wa[$], q_cyc[$];
    logic [31:0] q_dat[$];
    logic [31:0] exp_w;
    n      = yf ? 8 : 16;
    base   = !yf ? YB : (uf ? VB : UB);
    stride = yf ? UVS : YS;
    nn     = n * n;
    dcyc   = nn + LAT + 1;
    nonzero = 0;
    for (int r = 0; r < n; r++)
      for (int c2 = 0; c2 < n; c2++)
        if (sram_val(18'(ref_addr(base, stride, n, rb, cb, r, c2))) != 16'h0) nonzero = 1;
    Y_finished = yf; U_finished = uf; Rb = rb; Cb = cb; start = 1'b1;
    last_c = (rst_at > 0) ? rst_at + 20 : dcyc + 1;
    for (int c = 1; c <= last_c; c++) begin
      @(negedge Clock);
      if (rst_at > 0) begin
        if (c == rst_at + 1) chk_reset_outputs("mid_reset");
        if (c > rst_at) chk("no_write_after_reset", Write_en_Sp_a, 0);
      end else begin
        if (c <= nn) begin
          ri = (c - 1) % n;
          ci = (c - 1) / n;
          chk("sram_addr", SRAM_address, ref_addr(base, stride, n, rb, cb, ri, ci));
        end
        chk("busy", busy, c <= dcyc);
        chk("done", done, c == dcyc);
        chk("we_n", SRAM_we_n, 1);
`ifdef FETCH_SP_ZERO_DETECT_EN
        if (c == dcyc) chk("all_zero", all_zero, !nonzero);
`endif
        if (Write_en_Sp_a) begin
          q_wa.push_back(int'(Address_Sp_a));
          q_dat.push_back(Write_data_Sp_a);
          q_cyc.push_back(c);
        end
      end
      start = (c == sa1) || (c == sa2);
      Reset = (c == rst_at);
    end
    start = 1'b0;
    if (rst_at == 0) begin
      chk("write_count", q_wa.size(), nn / 2);
      for (int k = 0; k < q_wa.size() && k < nn / 2; k++) begin
        kk = k % (n / 2);
        ci = k / (n / 2);
        ri = 2 * kk;
        exp_w = {sram_val(18'(ref_addr(base, stride, n, rb, cb, ri, ci))),
                 sram_val(18'(ref_addr(base, stride, n, rb, cb, ri + 1, ci)))};
        chk("sp_addr", q_wa[k], k);
        chk("sp_data", q_dat[k], exp_w);
        chk("write_cycle", q_cyc[k], ci * n + ri + 2 + LAT);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; Y_finished = 1'b0; U_finished = 1'b0; Rb = '0; Cb = '0;
    repeat (3) @(negedge Clock);
    chk_reset_outputs("reset");
    Reset = 1'b0;
    @(negedge Clock);

    pat_mode = 0;
    run_fetch(1'b0, 1'b0, 8'd1, 8'd2, 0, 0, 0);     // Y block
    run_fetch(1'b1, 1'b0, 8'd0, 8'd0, 0, 0, 0);     // U block, starts the cycle after done
    run_fetch(1'b1, 1'b1, 8'd3, 8'd5, 0, 0, 0);     // V block
    run_fetch(1'b0, 1'b0, 8'd1, 8'd2, 0, 0, 40);    // reset mid-fetch
    run_fetch(1'b0, 1'b0, 8'd4, 8'd7, 10, 100, 0);  // start while busy
    run_fetch(1'b1, 1'b0, 8'd2, 8'd2, 67, 0, 0);    // start during done

    pat_mode = 2;
    seed = $urandom;
    for (int i = 0; i < 4; i++)
      run_fetch(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom), 8'($urandom), 0, 0, 0);
    run_fetch(1'b0, 1'b0, 8'd255, 8'd255, 0, 0, 0); // address wrap

    pat_mode = 1;
    nz_addr  = 18'd0;
    run_fetch(1'b0, 1'b0, 8'd2, 8'd3, 0, 0, 0);
    nz_addr  = 18'(ref_addr(YB, YS, 16, 2, 3, 15, 15));
    run_fetch(1'b0, 1'b0, 8'd2, 8'd3, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sprime_sram.md
Name: fetch_sprime_sram

Overview:
- Inverse-direction companion to the S'-to-SRAM writeback stage.
- Reads one pre-IDCT coefficient block (16x16 for Y, 8x8 for U/V) from external SRAM.
- Packs sample pairs into 32-bit words and writes them into port A of the embedded S' dual-port RAM.
- Sits between the SRAM arbiter and the IDCT datapath; pulses done when the full block is resident in embedded RAM.

Parameters:
- Y_BASE, 76800, SRAM word address of the Y coefficient plane.
- U_BASE, 153600, SRAM word address of the U coefficient plane.
- V_BASE, 192000, SRAM word address of the V coefficient plane.
- Y_STRIDE, 320, SRAM words per Y row.
- UV_STRIDE, 160, SRAM words per U/V row.
- SRAM_LAT, 2, SRAM read latency in cycles.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to fetch a block; ignored unless in S_IDLE.
- Y_finished  in  1  0 selects Y plane (16x16); sampled at start.
- U_finished  in  1  with Y_finished=1: 0 selects U, 1 selects V; sampled at start.
- Rb  in  8  block row index; sampled at start.
- Cb  in  8  block column index; sampled at start.
- SRAM_read_data  in  16  SRAM read bus.
- SRAM_address  out  18  SRAM word address.
- SRAM_we_n  out  1  SRAM write enable (active low); always 1.
- Address_Sp_a  out  8  embedded RAM port A address.
- Write_data_Sp_a  out  32  packed word: [31:16] even-row sample, [15:0] odd-row sample.
- Write_en_Sp_a  out  1  embedded RAM port A write enable.
- busy  out  1  high from the cycle after accepted start through the done cycle.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset values (applied at any edge with Reset=1, including mid-fetch):
  - All outputs 0 except SRAM_we_n=1.
  - State returns to S_IDLE; counters and pipeline valids are cleared; no further RAM writes occur.
- Mode is latched at start:
  - N=16, stride Y_STRIDE, base Y_BASE when Y_finished=0.
  - Otherwise N=8, stride UV_STRIDE, base U_BASE or V_BASE.
- Traversal:
  - ci is the outer loop and ri the inner loop, each running 0..N-1.
  - RA = Rb*N + ri; CA = Cb*N + ci.
  - SRAM_address = base + RA*stride + CA, truncated to 18 bits.
- States:
  - S_IDLE: on start, latch inputs, set busy, go to S_ISSUE.
  - S_ISSUE: drive one new address per cycle for N*N consecutive cycles. After the last address go to S_DRAIN.
  - S_DRAIN: wait for the outstanding reads and the final write, then go to S_DONE.
  - S_DONE: done=1 for one cycle; busy drops next cycle; return to S_IDLE.
- Read pipeline:
  - Data for the address driven in cycle n is valid on SRAM_read_data in cycle n+SRAM_LAT.
  - Track this with a SRAM_LAT-deep valid/parity shift register.
- Packing:
  - Even-ri sample is held in a 16-bit register.
  - On the odd-ri sample, Write_en_Sp_a=1 for one cycle with Write_data_Sp_a={even, odd}.
- Address_Sp_a:
  - Starts at 0 and increments by 1 after each write.
  - Word k holds ci = k/(N/2) and ri = 2*(k mod N/2).
  - Totals: 128 words (Y) or 32 words (U/V).
- Timing:
  - Cycle 1 is the first S_ISSUE cycle; the last address is driven in cycle N*N.
  - Final write occurs in cycle N*N+SRAM_LAT.
  - done is high in cycle N*N+SRAM_LAT+1.
- Boundary conditions:
  - start while busy is ignored.
  - start in the same cycle as done is ignored; it is accepted in the cycle after done.
  - Rb/Cb are not range-checked; address arithmetic wraps modulo 2^18.

Optional Feature:
- Macro: FETCH_SP_ZERO_DETECT_EN.
- When defined:
  - Adds output all_zero (1 bit, reset 0).
  - all_zero is cleared at accepted start.
  - In the done cycle it equals 1 iff every fetched sample was 16'h0000; it holds until the next start.
  - The IDCT uses it to skip the block.
- When undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Y block, Rb=1, Cb=2, SRAM[a]=a[15:0]:
  - first address 81952 (76800+16*320+32); addresses step by 320.
  - word 0 = {16'h4020, 16'h4160}; 128 writes; done in cycle 259.
- U block, Rb=0, Cb=0, Y_finished=1, U_finished=0:
  - addresses 153600, 153760, ...; 32 writes, Address_Sp_a 0..31.
  - last address 153600+7*160+7=154727; done in cycle 67.
- V block, Rb=3, Cb=5: first address 192000+24*160+40=195880; done cycle 67.
- Reset asserted in cycle 40 of a Y fetch:
  - next cycle all outputs are at reset values; no Write_en_Sp_a thereafter.
  - a fresh start then completes normally.
- start pulsed at cycles 10 and 100 of a Y fetch: ignored, so exactly 128 writes and one done pulse.
- With FETCH_SP_ZERO_DETECT_EN:
  - all-zero SRAM region gives all_zero=1 at done.
  - one nonzero sample at (ri=15, ci=15) gives all_zero=0.
